// File: rtl/alu_pkg.sv
// Shared ISA definitions for the ALU controller and the ALU bench:
// opcodes, controller states and instruction field positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLT   = 4'h5,
    OP_SHIFT = 4'h6,
    OP_ADDI  = 4'h9,
    OP_LDI   = 4'hA,
    OP_BEQ   = 4'hB,
    OP_BNE   = 4'hC,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS1_HI  = 8;
  localparam int RS1_LO  = 6;
  localparam int RS2_HI  = 5;
  localparam int RS2_LO  = 3;
  localparam int DIR_BIT = 2;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam int BRS1_HI = 11;
  localparam int BRS1_LO = 9;
  localparam int BRS2_HI = 8;
  localparam int BRS2_LO = 6;
  localparam int OFF_HI  = 5;
  localparam int OFF_LO  = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= 4'h6;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_ADDI) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8 x 8-bit register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero.
module regfile_8x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [2:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [2:0] raddr1_i,
  output logic [7:0] rdata1_o,
  input  logic [2:0] raddr2_i,
  output logic [7:0] rdata2_o
);
  logic [7:0][7:0] mem_q;

  // entry 0 is never written, so it stays at its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else if (we_i && (waddr_i != 3'd0)) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == 3'd0) ? 8'h00 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 3'd0) ? 8'h00 : mem_q[raddr2_i];

endmodule

// File: rtl/alu_controller.sv
// Multi-cycle controller: fetches 16-bit instructions, drives an external
// combinational ALU with registered operands and writes results back.
module alu_controller
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        instr_req,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_rdata,
  input  logic        instr_valid,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_dir,
  input  logic [7:0]  alu_result,
  input  logic        alu_branch_taken,
  output logic        busy,
  output logic        halted
);
  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  res_q, res_d;
  logic        bt_q, bt_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [3:0]  opc_q, opc_d;
  logic        dir_q, dir_d;

  logic [3:0]  op;
  logic        is_br;
  logic        we;
  logic [2:0]  raddr1, raddr2;
  logic [7:0]  rdata1, rdata2;

  assign op    = ir_q[OP_HI:OP_LO];
  assign is_br = (op == OP_BEQ) || (op == OP_BNE);

  // ADDI reads its destination; branches take rs1/rs2 from the upper fields
  assign raddr1 = (op == OP_ADDI) ? ir_q[RD_HI:RD_LO]   :
                  is_br           ? ir_q[BRS1_HI:BRS1_LO] : ir_q[RS1_HI:RS1_LO];
  assign raddr2 = is_br ? ir_q[BRS2_HI:BRS2_LO] : ir_q[RS2_HI:RS2_LO];

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .waddr_i  (ir_q[RD_HI:RD_LO]),
    .wdata_i  (res_q),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      res_q   <= '0;
      bt_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      bt_q    <= bt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    bt_d    = bt_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    dir_d   = dir_q;
    we      = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          pc_d    = 8'h00;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opc_d = op;
        dir_d = (op == OP_SHIFT) ? ir_q[DIR_BIT] : 1'b0;
        // operands not used by the instruction keep their previous value
        if (is_alu_op(op) || is_br) begin
          a_d = rdata1;
          b_d = rdata2;
        end else if (op == OP_ADDI) begin
          a_d = rdata1;
          b_d = ir_q[IMM_HI:IMM_LO];
        end else if (op == OP_LDI) begin
          b_d = ir_q[IMM_HI:IMM_LO];
        end
        state_d = (op == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        res_d   = alu_result;
        bt_d    = alu_branch_taken;
        state_d = WB;
      end
      WB: begin
        we      = writes_rd(op);
        pc_d    = (is_br && bt_q) ? pc_q + {{2{ir_q[OFF_HI]}}, ir_q[OFF_HI:OFF_LO]}
                                  : pc_q + 8'd1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_req  = (state_q == FETCH);
  assign instr_addr = pc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = opc_q;
  assign alu_dir    = dir_q;
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign halted     = (state_q == HALT);

endmodule
